// File: rtl/matmul_sequencer.sv
// Sequencer for one FP32 matrix multiply C = A x B on an external combinational MAC.
// Reads A/B headers, streams operand addresses (k inner, j, i outer) and writes each dot product.
module matmul_sequencer #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dut_valid,
  output logic                       dut_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_input_read_address,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_input_read_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_weight_read_address,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_weight_read_data,
  output logic                       sram_result_write_enable,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_result_write_address,
  output logic [SRAM_DATA_WIDTH-1:0] sram_result_write_data,
  output logic                       sram_input_write_enable,
  output logic                       sram_weight_write_enable,
  output logic [SRAM_DATA_WIDTH-1:0] mac_a,
  output logic [SRAM_DATA_WIDTH-1:0] mac_b,
  output logic [SRAM_DATA_WIDTH-1:0] mac_c,
  output logic [2:0]                 mac_rnd,
  input  logic [SRAM_DATA_WIDTH-1:0] mac_z,
  output logic                       error
);

  typedef enum logic [2:0] {IDLE, HDR, HDR_WAIT, RUN, DRAIN, DONE} state_t;

  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t state, state_next;

  logic [15:0] m_dim, k_dim, n_dim;
  logic [15:0] k_cnt, j_cnt, i_cnt;
  logic [SRAM_ADDR_WIDTH-1:0] a_base, b_base, c_idx, k_step;
  logic [SRAM_DATA_WIDTH-1:0] accum;
  logic first_d, last_d, valid_d;
  logic accept, running, hdr_ok, last_k, last_j, last_i;

  assign accept  = (state == IDLE) && dut_ready && dut_valid;
  assign running = (state == RUN);
  assign last_k  = (k_cnt == k_dim - 16'd1);
  assign last_j  = (j_cnt == n_dim - 16'd1);
  assign last_i  = (i_cnt == m_dim - 16'd1);
  assign k_step  = SRAM_ADDR_WIDTH'(k_dim);
  assign hdr_ok  = (sram_input_read_data[31:16] != 16'd0) &&
                   (sram_input_read_data[15:0] != 16'd0) &&
                   (sram_weight_read_data[15:0] != 16'd0) &&
                   (sram_input_read_data[15:0] == sram_weight_read_data[31:16]);

  // State register plus the registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dut_ready <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      dut_ready <= (state_next == IDLE);
      if (accept)
        error <= 1'b0;
      else if ((state == HDR_WAIT) && !hdr_ok)
        error <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = HDR;
      HDR:      state_next = HDR_WAIT;
      HDR_WAIT: state_next = hdr_ok ? RUN : DONE;
      RUN:      if (last_k && last_j && last_i) state_next = DRAIN;
      // DRAIN and DONE together span the data cycle and the final write cycle
      DRAIN:    state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    mac_a                    = sram_input_read_data;
    mac_b                    = sram_weight_read_data;
    mac_c                    = first_d ? '0 : accum;
    mac_rnd                  = 3'b000;
    sram_input_write_enable  = 1'b0;
    sram_weight_write_enable = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_input_read_address   <= '0;
      sram_weight_read_address  <= '0;
      sram_result_write_enable  <= 1'b0;
      sram_result_write_address <= '0;
      sram_result_write_data    <= '0;
      a_base  <= '0;
      b_base  <= '0;
      c_idx   <= '0;
      k_cnt   <= '0;
      j_cnt   <= '0;
      i_cnt   <= '0;
      m_dim   <= '0;
      k_dim   <= '0;
      n_dim   <= '0;
      accum   <= '0;
      first_d <= 1'b0;
      last_d  <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      // Tags follow the issued pair by one cycle, aligned with the returning operands
      first_d <= running && (k_cnt == 16'd0);
      last_d  <= running && last_k;
      valid_d <= running;
      sram_result_write_enable <= last_d;
      if (last_d) begin
        sram_result_write_data    <= mac_z;
        sram_result_write_address <= c_idx;
        c_idx                     <= c_idx + ADDR_ONE;
      end
      if (valid_d)
        accum <= mac_z;
      case (state)
        IDLE: begin
          if (accept) begin
            sram_input_read_address  <= '0;
            sram_weight_read_address <= '0;
            c_idx                    <= '0;
          end
        end
        HDR_WAIT: begin
          m_dim <= sram_input_read_data[31:16];
          k_dim <= sram_input_read_data[15:0];
          n_dim <= sram_weight_read_data[15:0];
          a_base <= ADDR_ONE;
          b_base <= ADDR_ONE;
          sram_input_read_address  <= ADDR_ONE;
          sram_weight_read_address <= ADDR_ONE;
          k_cnt <= '0;
          j_cnt <= '0;
          i_cnt <= '0;
        end
        RUN: begin
          if (!last_k) begin
            k_cnt <= k_cnt + 16'd1;
            sram_input_read_address  <= sram_input_read_address + ADDR_ONE;
            sram_weight_read_address <= sram_weight_read_address + ADDR_ONE;
          end else begin
            k_cnt <= '0;
            if (!last_j) begin
              j_cnt  <= j_cnt + 16'd1;
              b_base <= b_base + k_step;
              sram_input_read_address  <= a_base;
              sram_weight_read_address <= b_base + k_step;
            end else begin
              j_cnt  <= '0;
              i_cnt  <= i_cnt + 16'd1;
              a_base <= a_base + k_step;
              b_base <= ADDR_ONE;
              sram_input_read_address  <= a_base + k_step;
              sram_weight_read_address <= ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
